// File: rtl/matmul_pkg.sv
`default_nettype none
// ============================================================================
// Module   : matmul_pkg
// Brief    : Shared types, width helpers and cycle-count helper for matmul_mac_ctrl
// Revision : 1.0
// ============================================================================
package matmul_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_WAIT  = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    localparam int DEF_N     = 32;
    localparam int DEF_ROWS  = 4;
    localparam int DEF_INNER = 4;
    localparam int DEF_COLS  = 4;

    // A depth of one still needs a 1-bit index so ports never collapse to zero width.
    function automatic int idx_w(input int depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

    localparam int A_ADDR_W = idx_w(DEF_ROWS * DEF_INNER);
    localparam int B_ADDR_W = idx_w(DEF_INNER * DEF_COLS);
    localparam int C_ADDR_W = idx_w(DEF_ROWS * DEF_COLS);

    function automatic int total_cycles(input int rows, input int inner, input int cols);
        return rows * cols * (inner + 2) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/matmul_idx_counter.sv
`default_nettype none
// ============================================================================
// Module   : matmul_idx_counter
// Brief    : Nested (i,j,k) index counter; k is the inner MAC term, j wraps into i
// Revision : 1.0
// ============================================================================
module matmul_idx_counter
    import matmul_pkg::*;
#(
    parameter int ROWS  = DEF_ROWS,
    parameter int INNER = DEF_INNER,
    parameter int COLS  = DEF_COLS,
    parameter int IW    = idx_w(ROWS),
    parameter int KW    = idx_w(INNER),
    parameter int JW    = idx_w(COLS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_i,
    input  logic          inc_k_i,
    input  logic          inc_ij_i,
    output logic [IW-1:0] i_o,
    output logic [JW-1:0] j_o,
    output logic [KW-1:0] k_o,
    output logic          last_k_o,
    output logic          last_ij_o
);

    logic [IW-1:0] i_q, i_d;
    logic [JW-1:0] j_q, j_d;
    logic [KW-1:0] k_q, k_d;
    logic          last_i;
    logic          last_j;

    assign last_i    = (i_q == IW'(ROWS - 1));
    assign last_j    = (j_q == JW'(COLS - 1));
    assign last_k_o  = (k_q == KW'(INNER - 1));
    assign last_ij_o = last_i && last_j;

    always_comb begin
        i_d = i_q;
        j_d = j_q;
        k_d = k_q;
        if (clr_i) begin
            i_d = '0;
            j_d = '0;
            k_d = '0;
        end else begin
            // k wraps on its own so the next element's FETCH starts at k=0.
            if (inc_k_i) begin
                k_d = last_k_o ? '0 : k_q + KW'(1);
            end
            if (inc_ij_i) begin
                if (last_j) begin
                    j_d = '0;
                    i_d = last_i ? '0 : i_q + IW'(1);
                end else begin
                    j_d = j_q + JW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_q <= '0;
            j_q <= '0;
            k_q <= '0;
        end else begin
            i_q <= i_d;
            j_q <= j_d;
            k_q <= k_d;
        end
    end

    assign i_o = i_q;
    assign j_o = j_q;
    assign k_o = k_q;

endmodule
`default_nettype wire

// File: rtl/matmul_mac_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : matmul_mac_ctrl
// Brief    : Sequences operand reads, MAC strobes and C writes for C = A*B
// Revision : 1.0
// ============================================================================
module matmul_mac_ctrl
    import matmul_pkg::*;
#(
    parameter int N     = DEF_N,
    parameter int ROWS  = DEF_ROWS,
    parameter int INNER = DEF_INNER,
    parameter int COLS  = DEF_COLS,
    parameter int A_AW  = idx_w(ROWS * INNER),
    parameter int B_AW  = idx_w(INNER * COLS),
    parameter int C_AW  = idx_w(ROWS * COLS)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic            abort_i,
    output logic            busy_o,
    output logic            done_o,
    output logic            a_rd_en_o,
    output logic [A_AW-1:0] a_addr_o,
    output logic            b_rd_en_o,
    output logic [B_AW-1:0] b_addr_o,
    input  logic [N-1:0]    a_rd_data_i,
    input  logic [N-1:0]    b_rd_data_i,
    output logic [N-1:0]    mac_a_o,
    output logic [N-1:0]    mac_b_o,
    output logic            mac_valid_o,
    output logic            mac_clr_o,
    input  logic [2*N-1:0]  mac_acc_i,
    output logic            c_we_o,
    output logic [C_AW-1:0] c_addr_o,
    output logic [2*N-1:0]  c_data_o
);

    localparam int IW = idx_w(ROWS);
    localparam int KW = idx_w(INNER);
    localparam int JW = idx_w(COLS);

    state_e        state_q, state_d;
    logic          mac_valid_q, mac_valid_d;
    logic          mac_clr_q, mac_clr_d;
    logic          rd_en;
    logic          c_we;
    logic          done;
    logic          last_k;
    logic          last_ij;
    logic [IW-1:0] row_idx;
    logic [JW-1:0] col_idx;
    logic [KW-1:0] k_idx;

    matmul_idx_counter #(
        .ROWS  (ROWS),
        .INNER (INNER),
        .COLS  (COLS),
        .IW    (IW),
        .KW    (KW),
        .JW    (JW)
    ) u_idx (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (state_q == ST_IDLE),
        .inc_k_i   (rd_en),
        .inc_ij_i  (c_we),
        .i_o       (row_idx),
        .j_o       (col_idx),
        .k_o       (k_idx),
        .last_k_o  (last_k),
        .last_ij_o (last_ij)
    );

    // An abort cycle suppresses every strobe, so nothing leaks past the cancel.
    always_comb begin
        state_d = state_q;
        rd_en   = 1'b0;
        c_we    = 1'b0;
        done    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (abort_i) begin
                    state_d = ST_IDLE;
                end else begin
                    rd_en = 1'b1;
                    if (last_k) begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                state_d = abort_i ? ST_IDLE : ST_WRITE;
            end
            ST_WRITE: begin
                if (abort_i) begin
                    state_d = ST_IDLE;
                end else begin
                    c_we    = 1'b1;
                    state_d = last_ij ? ST_DONE : ST_FETCH;
                end
            end
            ST_DONE: begin
                done    = !abort_i;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign mac_valid_d = rd_en;
    assign mac_clr_d   = rd_en && (k_idx == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            mac_valid_q <= 1'b0;
            mac_clr_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            mac_valid_q <= mac_valid_d;
            mac_clr_q   <= mac_clr_d;
        end
    end

    assign busy_o    = (state_q != ST_IDLE);
    assign done_o    = done;
    assign a_rd_en_o = rd_en;
    assign b_rd_en_o = rd_en;

    // Constant multipliers reduce to shift-adds.
    assign a_addr_o = rd_en ? (A_AW'(row_idx) * A_AW'(INNER) + A_AW'(k_idx)) : '0;
    assign b_addr_o = rd_en ? (B_AW'(k_idx) * B_AW'(COLS) + B_AW'(col_idx)) : '0;
    assign c_addr_o = c_we  ? (C_AW'(row_idx) * C_AW'(COLS) + C_AW'(col_idx)) : '0;

    // Memory data arrives one cycle after rd_en, which lines up with the strobe register.
    assign mac_a_o     = mac_valid_q ? a_rd_data_i : '0;
    assign mac_b_o     = mac_valid_q ? b_rd_data_i : '0;
    assign mac_valid_o = mac_valid_q;
    assign mac_clr_o   = mac_clr_q;

    assign c_we_o   = c_we;
    assign c_data_o = c_we ? mac_acc_i : '0;

endmodule
`default_nettype wire

// File: tb/tb_matmul_mac_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_matmul_mac_ctrl
// Brief    : Directed bench for matmul_mac_ctrl (2x2x2, 1x1x1 and 8-bit wrap cases)
// Revision : 1.0
// ============================================================================
module tb_matmul_mac_ctrl;
    import matmul_pkg::*;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- main instance: 2x2x2, N=32 ----------------
    logic        m_start, m_abort, m_busy, m_done;
    logic        m_a_rd_en, m_b_rd_en, m_mac_valid, m_mac_clr, m_c_we;
    logic [1:0]  m_a_addr, m_b_addr, m_c_addr;
    logic [31:0] m_a_rd, m_b_rd, m_mac_a, m_mac_b;
    logic [63:0] m_acc, m_c_data;
    logic [31:0] mem_a [4];
    logic [31:0] mem_b [4];

    matmul_mac_ctrl #(.N(32), .ROWS(2), .INNER(2), .COLS(2)) u_m (
        .clk(clk), .rst_n(rst_n), .start_i(m_start), .abort_i(m_abort),
        .busy_o(m_busy), .done_o(m_done),
        .a_rd_en_o(m_a_rd_en), .a_addr_o(m_a_addr), .b_rd_en_o(m_b_rd_en), .b_addr_o(m_b_addr),
        .a_rd_data_i(m_a_rd), .b_rd_data_i(m_b_rd), .mac_a_o(m_mac_a), .mac_b_o(m_mac_b),
        .mac_valid_o(m_mac_valid), .mac_clr_o(m_mac_clr), .mac_acc_i(m_acc),
        .c_we_o(m_c_we), .c_addr_o(m_c_addr), .c_data_o(m_c_data)
    );

    always @(posedge clk) begin
        if (m_a_rd_en) m_a_rd <= mem_a[m_a_addr];
        if (m_b_rd_en) m_b_rd <= mem_b[m_b_addr];
        if (m_mac_valid)
            m_acc <= m_mac_clr ? 64'(m_mac_a) * 64'(m_mac_b) : m_acc + 64'(m_mac_a) * 64'(m_mac_b);
    end

    // ---------------- single-term instance: 1x1x1, N=32 ----------------
    logic        s_start, s_abort, s_busy, s_done;
    logic        s_a_rd_en, s_b_rd_en, s_mac_valid, s_mac_clr, s_c_we;
    logic [0:0]  s_a_addr, s_b_addr, s_c_addr;
    logic [31:0] s_a_rd, s_b_rd, s_mac_a, s_mac_b;
    logic [63:0] s_acc, s_c_data;

    matmul_mac_ctrl #(.N(32), .ROWS(1), .INNER(1), .COLS(1)) u_s (
        .clk(clk), .rst_n(rst_n), .start_i(s_start), .abort_i(s_abort),
        .busy_o(s_busy), .done_o(s_done),
        .a_rd_en_o(s_a_rd_en), .a_addr_o(s_a_addr), .b_rd_en_o(s_b_rd_en), .b_addr_o(s_b_addr),
        .a_rd_data_i(s_a_rd), .b_rd_data_i(s_b_rd), .mac_a_o(s_mac_a), .mac_b_o(s_mac_b),
        .mac_valid_o(s_mac_valid), .mac_clr_o(s_mac_clr), .mac_acc_i(s_acc),
        .c_we_o(s_c_we), .c_addr_o(s_c_addr), .c_data_o(s_c_data)
    );

    always @(posedge clk) begin
        s_a_rd <= s_a_rd_en ? 32'd7 : 32'd0;
        s_b_rd <= s_b_rd_en ? 32'd9 : 32'd0;
        if (s_mac_valid)
            s_acc <= s_mac_clr ? 64'(s_mac_a) * 64'(s_mac_b) : s_acc + 64'(s_mac_a) * 64'(s_mac_b);
    end

    // ---------------- wrap instance: 1x4x2, N=8 ----------------
    logic        w_start, w_abort, w_busy, w_done;
    logic        w_a_rd_en, w_b_rd_en, w_mac_valid, w_mac_clr, w_c_we;
    logic [1:0]  w_a_addr;
    logic [2:0]  w_b_addr;
    logic [0:0]  w_c_addr;
    logic [7:0]  w_a_rd, w_b_rd, w_mac_a, w_mac_b;
    logic [15:0] w_acc, w_c_data;

    matmul_mac_ctrl #(.N(8), .ROWS(1), .INNER(4), .COLS(2)) u_w (
        .clk(clk), .rst_n(rst_n), .start_i(w_start), .abort_i(w_abort),
        .busy_o(w_busy), .done_o(w_done),
        .a_rd_en_o(w_a_rd_en), .a_addr_o(w_a_addr), .b_rd_en_o(w_b_rd_en), .b_addr_o(w_b_addr),
        .a_rd_data_i(w_a_rd), .b_rd_data_i(w_b_rd), .mac_a_o(w_mac_a), .mac_b_o(w_mac_b),
        .mac_valid_o(w_mac_valid), .mac_clr_o(w_mac_clr), .mac_acc_i(w_acc),
        .c_we_o(w_c_we), .c_addr_o(w_c_addr), .c_data_o(w_c_data)
    );

    always @(posedge clk) begin
        w_a_rd <= w_a_rd_en ? 8'hFF : 8'h00;
        w_b_rd <= w_b_rd_en ? 8'hFF : 8'h00;
        if (w_mac_valid)
            w_acc <= w_mac_clr ? 16'(w_mac_a) * 16'(w_mac_b) : w_acc + 16'(w_mac_a) * 16'(w_mac_b);
    end

    // ---------------- checking and logging ----------------
    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    logic        lg_busy [64];
    logic        lg_mv   [64];
    logic        lg_clr  [64];
    logic        lg_zero [64];
    logic [1:0]  lg_aa   [64];
    logic [1:0]  lg_ba   [64];
    int          we_c [$];
    int          we_a [$];
    logic [63:0] we_d [$];
    int          done_c [$];

    // Cycle c is sampled mid-cycle; inputs set here are seen at the edge ending cycle c.
    task automatic run_main(input int s0, input int s1, input int s2, input int s3,
                            input int ab, input int rs, input int ncyc);
        we_c.delete(); we_a.delete(); we_d.delete(); done_c.delete();
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            if (c == rs) begin
                rst_n = 1'b0;
                #1;
            end else if (rs >= 0 && c == rs + 1) begin
                rst_n = 1'b1;
            end
            lg_busy[c] = m_busy;
            lg_mv[c]   = m_mac_valid;
            lg_clr[c]  = m_mac_clr;
            lg_aa[c]   = m_a_addr;
            lg_ba[c]   = m_b_addr;
            lg_zero[c] = ({m_busy, m_done, m_a_rd_en, m_b_rd_en, m_mac_valid, m_mac_clr, m_c_we} == '0)
                      && (m_a_addr == '0) && (m_b_addr == '0) && (m_c_addr == '0)
                      && (m_mac_a == '0) && (m_mac_b == '0) && (m_c_data == '0);
            if (m_c_we) begin
                we_c.push_back(c);
                we_a.push_back(int'(m_c_addr));
                we_d.push_back(m_c_data);
            end
            if (m_done) done_c.push_back(c);
            m_start = (c == s0) || (c == s1) || (c == s2) || (c == s3);
            m_abort = (c == ab);
        end
        m_start = 1'b0;
        m_abort = 1'b0;
    endtask

    // Expected 2x2x2 results: [1 2;3 4]*[5 6;7 8].
    task automatic check_writes(input string p, input int first, input int base);
        logic [63:0] exp_c [4];
        exp_c[0] = 64'd19; exp_c[1] = 64'd22; exp_c[2] = 64'd43; exp_c[3] = 64'd50;
        for (int n = 0; n < 4; n++) begin
            if (we_c.size() > first + n) begin
                check_eq($sformatf("%s_we%0d_cyc", p, n), 64'(we_c[first + n]), 64'(base + 4 + 4 * n));
                check_eq($sformatf("%s_we%0d_addr", p, n), 64'(we_a[first + n]), 64'(n));
                check_eq($sformatf("%s_we%0d_data", p, n), we_d[first + n], exp_c[n]);
            end else begin
                check_eq($sformatf("%s_we%0d_present", p, n), 64'd0, 64'd1);
            end
        end
    endtask

    initial begin
        int cnt;
        int s_done_at;
        int w_done_at;
        int w_we_n;
        n_checks = 0;
        n_fail   = 0;
        rst_n   = 1'b0;
        m_start = 1'b0; m_abort = 1'b0;
        s_start = 1'b0; s_abort = 1'b0;
        w_start = 1'b0; w_abort = 1'b0;
        m_acc = '0; s_acc = '0; w_acc = '0;
        mem_a[0] = 32'd1; mem_a[1] = 32'd2; mem_a[2] = 32'd3; mem_a[3] = 32'd4;
        mem_b[0] = 32'd5; mem_b[1] = 32'd6; mem_b[2] = 32'd7; mem_b[3] = 32'd8;

        // Reset state
        repeat (3) @(negedge clk);
        check_eq("rst_busy", 64'(m_busy), 64'd0);
        check_eq("rst_rd_en", 64'({m_a_rd_en, m_b_rd_en}), 64'd0);
        check_eq("rst_mac", 64'({m_mac_valid, m_mac_clr}), 64'd0);
        check_eq("rst_c", 64'({m_c_we, m_c_addr}), 64'd0);
        check_eq("rst_c_data", m_c_data, 64'd0);
        rst_n = 1'b1;

        // Functional 2x2x2; abort coincides with start in IDLE and must be ignored
        run_main(0, -1, -1, -1, 0, -1, 24);
        check_eq("f_we_count", 64'(we_c.size()), 64'd4);
        check_writes("f", 0, 0);
        check_eq("f_done_count", 64'(done_c.size()), 64'd1);
        if (done_c.size() > 0) check_eq("f_done_cyc", 64'(done_c[0]), 64'd17);
        check_eq("f_busy_c0", 64'(lg_busy[0]), 64'd0);
        check_eq("f_busy_c1", 64'(lg_busy[1]), 64'd1);
        check_eq("f_busy_c17", 64'(lg_busy[17]), 64'd1);
        check_eq("f_busy_c18", 64'(lg_busy[18]), 64'd0);
        check_eq("f_mv_c1", 64'(lg_mv[1]), 64'd0);
        check_eq("f_mv_c2", 64'(lg_mv[2]), 64'd1);
        check_eq("f_mv_c3", 64'(lg_mv[3]), 64'd1);
        check_eq("f_mv_c4", 64'(lg_mv[4]), 64'd0);
        check_eq("f_clr_c2", 64'(lg_clr[2]), 64'd1);
        check_eq("f_clr_c3", 64'(lg_clr[3]), 64'd0);
        check_eq("f_clr_c6", 64'(lg_clr[6]), 64'd1);
        check_eq("f_aaddr_c2", 64'(lg_aa[2]), 64'd1);
        check_eq("f_baddr_c2", 64'(lg_ba[2]), 64'd2);
        check_eq("f_baddr_c5", 64'(lg_ba[5]), 64'd1);
        check_eq("f_aaddr_c10", 64'(lg_aa[10]), 64'd3);
        check_eq("f_baddr_c10", 64'(lg_ba[10]), 64'd2);
        check_eq("f_total_fn", 64'(total_cycles(2, 2, 2)), 64'd17);

        // Abort at cycle 6
        run_main(0, -1, -1, -1, 6, -1, 20);
        check_eq("ab_we_count", 64'(we_c.size()), 64'd1);
        if (we_c.size() > 0) check_eq("ab_we_cyc", 64'(we_c[0]), 64'd4);
        check_eq("ab_done_count", 64'(done_c.size()), 64'd0);
        check_eq("ab_busy_c6", 64'(lg_busy[6]), 64'd1);
        check_eq("ab_busy_c7", 64'(lg_busy[7]), 64'd0);
        cnt = 0;
        for (int c = 7; c < 20; c++) cnt += int'(lg_mv[c]);
        check_eq("ab_mv_after", 64'(cnt), 64'd0);

        // Reset mid-run at cycle 9
        run_main(0, -1, -1, -1, -1, 9, 30);
        check_eq("rs_zero_c9", 64'(lg_zero[9]), 64'd1);
        check_eq("rs_we_count", 64'(we_c.size()), 64'd2);
        check_eq("rs_done_count", 64'(done_c.size()), 64'd0);
        cnt = 0;
        for (int c = 9; c < 30; c++) cnt += int'(lg_busy[c]);
        check_eq("rs_busy_after", 64'(cnt), 64'd0);

        // Start while busy is ignored; a start right after DONE runs fully
        run_main(0, 3, 10, 18, -1, -1, 40);
        check_eq("sb_we_count", 64'(we_c.size()), 64'd8);
        check_writes("sb1", 0, 0);
        check_writes("sb2", 4, 18);
        check_eq("sb_done_count", 64'(done_c.size()), 64'd2);
        if (done_c.size() > 1) begin
            check_eq("sb_done0_cyc", 64'(done_c[0]), 64'd17);
            check_eq("sb_done1_cyc", 64'(done_c[1]), 64'd35);
        end
        check_eq("sb_busy_c18", 64'(lg_busy[18]), 64'd0);

        // Single term: INNER=1
        s_done_at = -1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (c == 2) begin
                check_eq("s_mv_c2", 64'(s_mac_valid), 64'd1);
                check_eq("s_clr_c2", 64'(s_mac_clr), 64'd1);
                check_eq("s_maca_c2", 64'(s_mac_a), 64'd7);
            end
            if (c == 3) begin
                check_eq("s_we_c3", 64'(s_c_we), 64'd1);
                check_eq("s_data_c3", s_c_data, 64'd63);
            end
            if (s_done && s_done_at < 0) s_done_at = c;
            s_start = (c == 0);
        end
        s_start = 1'b0;
        check_eq("s_done_cyc", 64'(s_done_at), 64'd4);

        // Wrap-around: 4 * 0xFF*0xFF mod 2^16
        w_done_at = -1;
        w_we_n = 0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (w_c_we) begin
                check_eq($sformatf("w_we%0d_cyc", w_we_n), 64'(c), 64'(6 + 6 * w_we_n));
                check_eq($sformatf("w_we%0d_data", w_we_n), 64'(w_c_data), 64'd63492);
                w_we_n++;
            end
            if (w_done && w_done_at < 0) w_done_at = c;
            w_start = (c == 0);
        end
        w_start = 1'b0;
        check_eq("w_we_count", 64'(w_we_n), 64'd2);
        check_eq("w_done_cyc", 64'(w_done_at), 64'd13);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
